multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RISC-V core: decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and write-back steps. It is the producer of the 2-bit ALU operation class consumed by the ALU control decoder, and it drives every datapath enable and mux select. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- No parameters.
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  7  instruction register bits [6:0]
- zero  in  1  ALU zero flag (used by datapath PC-write gating only; not sampled by FSM)
- mem_ready  in  1  memory completes current access this cycle
- pc_write, pc_write_cond  out  1  unconditional / branch-conditional PC load
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1  memory strobes
- ir_write  out  1  load instruction register and OldPC
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = reg A, 10 = OldPC
- alu_src_b  out  2  00 = reg B, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct fields
- pc_source  out  1  0 = ALU result, 1 = ALUOut
- illegal_op  out  1  one-cycle pulse: unsupported opcode in DECODE
- retire  out  1  one-cycle pulse: instruction completed
- state  out  4  current state encoding (debug)

## Operation
- States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_COMPLETE 7, BRANCH 8. Codes 9-15 unreachable; if entered, next state is FETCH.
- Outputs are a function of state (plus mem_ready where noted); every output not listed is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready. Stay while mem_ready=0; go DECODE on mem_ready=1.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next by opcode: 0000011 (lw) or 0100011 (sw) -> MEM_ADDR; 0110011 (R-type) -> EXECUTE; 1100011 (beq) -> BRANCH; anything else -> FETCH with illegal_op=1.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next MEM_READ for lw, MEM_WRITE for sw (opcode held stable by IR).
- MEM_READ: mem_read=1, i_or_d=1; stay until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, retire=1; next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; stay until mem_ready; retire=mem_ready; then FETCH.
- EXECUTE: alu_src_a=01, alu_src_b=00, alu_op=10; next R_COMPLETE.
- R_COMPLETE: reg_write=1, mem_to_reg=0, retire=1; next FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, retire=1; next FETCH.
- Strobes mem_read/mem_write stay asserted throughout a stall; ir_write and pc_write assert only in the ready cycle, so IR and PC load exactly once per fetch.

## Timing
- Reset: on a rising edge with rst_n=0, state <= FETCH. While rst_n=0 all outputs except state are forced 0 combinationally, including mid-access (memory strobes drop in the reset cycle). First cycle after release is FETCH.
- Latency with mem_ready=1 throughout: lw 5 cycles, sw 4, R-type 4, beq 3, illegal 2 (FETCH, DECODE).
- Each stall cycle adds one cycle in FETCH/MEM_READ/MEM_WRITE; mem_ready outside those states is ignored.
- illegal_op and retire are never asserted in the same cycle; at most one retire per instruction.

## Test plan
- Reset then lw (opcode 0x03), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in state 4; retire pulses once.
- R-type (0x33) -> states 0,1,6,7,0; alu_op=10 in state 6; reg_write=1, mem_to_reg=0 in state 7.
- beq (0x63) -> 0,1,8,0; in state 8 alu_op=01, pc_write_cond=1, pc_source=1; pc_write=0.
- FETCH with mem_ready low 3 cycles -> 4 cycles in FETCH, mem_read=1 all four, ir_write/pc_write high only in fourth.
- Opcode 0x7F -> illegal_op=1 for one cycle in DECODE, back to FETCH; reg_write, mem_write, retire never assert.
- sw (0x23) with rst_n driven low during MEM_WRITE stall -> mem_write=0 that cycle, state=0 next cycle, normal fetch after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V core. It sequences the datapath
// through fetch, decode, execute, memory and write-back steps. It drives every
// datapath enable and mux select, and it stalls on the memory ready handshake.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       pc_source,
   output logic       illegal_op,
   output logic       retire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH      = 4'd0,
      DECODE     = 4'd1,
      MEM_ADDR   = 4'd2,
      MEM_READ   = 4'd3,
      MEM_WB     = 4'd4,
      MEM_WRITE  = 4'd5,
      EXECUTE    = 4'd6,
      R_COMPLETE = 4'd7,
      BRANCH     = 4'd8
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   state_t state_reg;
   state_t state_next;

   // The zero flag gates PC writes in the datapath only; the FSM never looks at it.
   logic unused_zero;
   assign unused_zero = zero;

   // State register: a synchronous reset returns the FSM to FETCH.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= FETCH;
      else        state_reg <= state_next;
   end

   // Next-state logic and control outputs. Outputs are decoded from the state,
   // plus mem_ready in the memory states, and they are all forced low during reset.
   always_comb begin
      state_next    = FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 1'b0;
      illegal_op    = 1'b0;
      retire        = 1'b0;
      case (state_reg)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            case (opcode)
               OP_LW, OP_SW: state_next = MEM_ADDR;
               OP_R:         state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               default: begin
                  state_next = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            state_next = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            mem_read   = 1'b1;
            i_or_d     = 1'b1;
            state_next = mem_ready ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end
         MEM_WRITE: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            retire     = mem_ready;
            state_next = mem_ready ? FETCH : MEM_WRITE;
         end
         EXECUTE: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b00;
            alu_op     = 2'b10;
            state_next = R_COMPLETE;
         end
         R_COMPLETE: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 2'b01;
            alu_src_b     = 2'b00;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
            retire        = 1'b1;
            state_next    = FETCH;
         end
         default: state_next = FETCH;
      endcase
      if (!rst_n) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 2'b00;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 1'b0;
         illegal_op    = 1'b0;
         retire        = 1'b0;
      end
   end

   assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Random instruction streams with
// random memory stalls are compared, cycle by cycle, against a step-list model.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_write, pc_source, illegal_op, retire;
   logic [1:0] alu_src_a, alu_src_b, alu_op;
   logic [3:0] state;

   int n_vectors = 0;
   int n_fail    = 0;
   int force_fetch_stalls = -1;

   localparam logic [6:0] LW = 7'h03, SW = 7'h23, RT = 7'h33, BEQ = 7'h63;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .illegal_op(illegal_op), .retire(retire), .state(state)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Packed control outputs:
   // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
   //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retire}
   function automatic logic [16:0] word_now();
      return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retire};
   endfunction

   // Expected control outputs for each state of the control table.
   function automatic logic [16:0] exp_word(input int st, input bit rdy, input bit ill);
      logic pw, pwc, iod, mr, mw, irw, m2r, rw, pcs, il, ret;
      logic [1:0] sa, sb, op;
      {pw, pwc, iod, mr, mw, irw, m2r, rw, pcs, il, ret} = '0;
      sa = 2'b00; sb = 2'b00; op = 2'b00;
      case (st)
         0: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
         1: begin sa = 2'b10; sb = 2'b10; il = ill; end
         2: begin sa = 2'b01; sb = 2'b10; end
         3: begin mr = 1; iod = 1; end
         4: begin rw = 1; m2r = 1; ret = 1; end
         5: begin mw = 1; iod = 1; ret = rdy; end
         6: begin sa = 2'b01; op = 2'b10; end
         7: begin rw = 1; ret = 1; end
         8: begin sa = 2'b01; op = 2'b01; pwc = 1; pcs = 1; ret = 1; end
         default: ;
      endcase
      return {pw, pwc, iod, mr, mw, irw, m2r, rw, sa, sb, op, pcs, il, ret};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return (op == LW) || (op == SW) || (op == RT) || (op == BEQ);
   endfunction

   // Runs one instruction from FETCH to its final cycle. On entry and on exit
   // the bench sits at a falling edge, and inputs change only there.
   task automatic run_instr(input logic [6:0] op);
      int steps[$];
      int retires = 0, ills = 0, cycles = 0, stalls_total = 0, base;
      bit ill, mem_step, rdy;
      int stalls;
      ill = !is_legal(op);
      case (op)
         LW:      steps = '{0, 1, 2, 3, 4};
         SW:      steps = '{0, 1, 2, 5};
         RT:      steps = '{0, 1, 6, 7};
         BEQ:     steps = '{0, 1, 8};
         default: steps = '{0, 1};
      endcase
      base = steps.size();
      foreach (steps[k]) begin
         mem_step = (steps[k] == 0) || (steps[k] == 3) || (steps[k] == 5);
         stalls = 0;
         do begin
            if (steps[k] == 0 && force_fetch_stalls >= 0)
               rdy = (stalls >= force_fetch_stalls);
            else if (mem_step)
               rdy = (stalls >= 4) || ($urandom_range(0, 3) != 0);
            else
               rdy = 1'($urandom_range(0, 1));
            opcode    = op;
            mem_ready = rdy;
            zero      = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("state op=%02h step=%0d", op, k), 32'(state), 32'(steps[k]));
            check($sformatf("ctrl op=%02h st=%0d rdy=%0d", op, steps[k], rdy),
                  32'(word_now()), 32'(exp_word(steps[k], rdy, ill)));
            retires += int'(retire);
            ills    += int'(illegal_op);
            cycles++;
            if (mem_step && !rdy) begin stalls++; stalls_total++; end
            @(negedge clk);
         end while (mem_step && !rdy);
      end
      check($sformatf("retire count op=%02h", op), 32'(retires), ill ? 32'd0 : 32'd1);
      check($sformatf("illegal count op=%02h", op), 32'(ills), ill ? 32'd1 : 32'd0);
      check($sformatf("latency op=%02h", op), 32'(cycles),
            32'((op == LW) ? 5 : (op == SW || op == RT) ? 4 : (op == BEQ) ? 3 : 2) + 32'(stalls_total));
      $display("instr op=%02h cycles=%0d stalls=%0d retires=%0d illegal=%0d",
               op, cycles, stalls_total, retires, ills);
   endtask

   // Drives a single cycle with fixed inputs and checks it against the model.
   task automatic one_cycle(input logic [6:0] op, input bit rdy, input int exp_st,
                            input logic [16:0] exp_w, input string tag);
      opcode = op; mem_ready = rdy;
      #1;
      check({tag, " state"}, 32'(state), 32'(exp_st));
      check({tag, " ctrl"}, 32'(word_now()), 32'(exp_w));
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] op;
      rst_n = 1'b0; opcode = 7'h00; zero = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      // Outputs stay low while reset is held, even though mem_ready is high.
      opcode = LW; mem_ready = 1'b1; #1;
      check("reset ctrl", 32'(word_now()), 32'd0);
      check("reset state", 32'(state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases from the test plan.
      run_instr(LW);
      run_instr(RT);
      run_instr(BEQ);
      force_fetch_stalls = 3;
      run_instr(RT);
      force_fetch_stalls = -1;
      run_instr(7'h7F);

      // sw with reset asserted during a MEM_WRITE stall.
      one_cycle(SW, 1'b1, 0, exp_word(0, 1'b1, 1'b0), "swrst fetch");
      one_cycle(SW, 1'b1, 1, exp_word(1, 1'b1, 1'b0), "swrst decode");
      one_cycle(SW, 1'b1, 2, exp_word(2, 1'b1, 1'b0), "swrst addr");
      one_cycle(SW, 1'b0, 5, exp_word(5, 1'b0, 1'b0), "swrst stall");
      rst_n = 1'b0;
      one_cycle(SW, 1'b0, 5, 17'd0, "swrst in reset");
      rst_n = 1'b1;
      $display("sw interrupted by reset; resuming with lw");
      run_instr(LW);

      // Random instruction mix.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0: op = LW;
            1: op = SW;
            2: op = RT;
            3: op = BEQ;
            default: begin
               op = 7'($urandom);
               if (is_legal(op)) op = 7'h7F;
            end
         endcase
         run_instr(op);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
      $finish;
   end

endmodule
